// File: rtl/muldiv_sched_if.sv
// Bundle of the EX-stage request port, the mul/div controller handshakes and
// the architectural HI/LO view seen by muldiv_sched.
interface muldiv_sched_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;

  logic        mul_begin;
  logic        mul_sign;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_res;
  logic        mul_done;

  logic        div_begin;
  logic        div_sign;
  logic        div_dividend_sign;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_done;

  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        timeout;

  // master: pipeline plus controllers driving the scheduler
  modport master (
    output req_valid, req_op, a, b, flush, mul_res, mul_done,
           div_quotient, div_remainder, div_done,
    input  mul_begin, mul_sign, mul_a, mul_b, div_begin, div_sign,
           div_dividend_sign, div_dividend, div_divisor, stall, hi, lo, timeout
  );

  modport slave (
    input  req_valid, req_op, a, b, flush, mul_res, mul_done,
           div_quotient, div_remainder, div_done,
    output mul_begin, mul_sign, mul_a, mul_b, div_begin, div_sign,
           div_dividend_sign, div_dividend, div_divisor, stall, hi, lo, timeout
  );
endinterface

// File: rtl/muldiv_sched.sv
// HI/LO scheduler: launches MULT/DIV-class ops into external controllers,
// stalls EX while they run, owns HI/LO, and abandons ops on flush or watchdog.
module muldiv_sched #(
  parameter int MAX_WAIT = 40
) (
  input logic           clk,
  input logic           rst,
  muldiv_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;

  localparam int            CW        = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   hi_q, lo_q, mul_a_q, mul_b_q, div_dividend_q, div_divisor_q;
  logic          mul_sign_q, div_sign_q, div_dividend_sign_q, timeout_q;
  logic          op_signed, start_mul, start_div, mul_hit, div_hit, expire;
  logic          stall_c;

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // Even opcodes (MULT, DIV) are the signed variants.
  assign op_signed = ~bus.req_op[0];
  assign start_mul = (state == IDLE) && bus.req_valid && !bus.flush &&
                     (bus.req_op == 3'd0 || bus.req_op == 3'd1);
  assign start_div = (state == IDLE) && bus.req_valid && !bus.flush &&
                     (bus.req_op == 3'd2 || bus.req_op == 3'd3) && (bus.b != 32'd0);
  assign mul_hit   = (state == MUL_WAIT) && bus.mul_done;
  assign div_hit   = (state == DIV_WAIT) && bus.div_done;
  assign expire    = (state != IDLE) && (wait_cnt == LAST_WAIT);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_next = state;
    stall_c    = 1'b0;
    unique case (state)
      IDLE: begin
        stall_c = start_mul || start_div;
        if (start_mul)      state_next = MUL_WAIT;
        else if (start_div) state_next = DIV_WAIT;
      end
      MUL_WAIT: begin
        stall_c = !bus.flush && !bus.mul_done;
        if (bus.flush || bus.mul_done || expire) state_next = IDLE;
      end
      DIV_WAIT: begin
        stall_c = !bus.flush && !bus.div_done;
        if (bus.flush || bus.div_done || expire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) stall_c = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state               <= IDLE;
      wait_cnt            <= '0;
      hi_q                <= '0;
      lo_q                <= '0;
      mul_sign_q          <= 1'b0;
      mul_a_q             <= '0;
      mul_b_q             <= '0;
      div_sign_q          <= 1'b0;
      div_dividend_sign_q <= 1'b0;
      div_dividend_q      <= '0;
      div_divisor_q       <= '0;
      timeout_q           <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= (state == IDLE) ? '0 : wait_cnt + 1'b1;
      timeout_q <= expire && !bus.flush && !mul_hit && !div_hit;

      if (start_mul) begin
        mul_sign_q <= op_signed & (bus.a[31] ^ bus.b[31]);
        mul_a_q    <= op_signed ? mag(bus.a) : bus.a;
        mul_b_q    <= op_signed ? mag(bus.b) : bus.b;
      end else if (start_div) begin
        div_sign_q          <= op_signed & (bus.a[31] ^ bus.b[31]);
        div_dividend_sign_q <= op_signed & bus.a[31];
        div_dividend_q      <= op_signed ? mag(bus.a) : bus.a;
        div_divisor_q       <= op_signed ? mag(bus.b) : bus.b;
      end else if (state_next == IDLE) begin
        mul_sign_q          <= 1'b0;
        mul_a_q             <= '0;
        mul_b_q             <= '0;
        div_sign_q          <= 1'b0;
        div_dividend_sign_q <= 1'b0;
        div_dividend_q      <= '0;
        div_divisor_q       <= '0;
      end

      // A flush discards any completing result and any MTHI/MTLO in flight.
      if (!bus.flush) begin
        if (mul_hit) begin
          hi_q <= bus.mul_res[63:32];
          lo_q <= bus.mul_res[31:0];
        end else if (div_hit) begin
          hi_q <= bus.div_remainder;
          lo_q <= bus.div_quotient;
        end else if (state == IDLE && bus.req_valid && bus.req_op == 3'd4) begin
          hi_q <= bus.a;
        end else if (state == IDLE && bus.req_valid && bus.req_op == 3'd5) begin
          lo_q <= bus.a;
        end
      end
    end
  end

  assign bus.mul_begin         = (state == MUL_WAIT);
  assign bus.div_begin         = (state == DIV_WAIT);
  assign bus.mul_sign          = mul_sign_q;
  assign bus.mul_a             = mul_a_q;
  assign bus.mul_b             = mul_b_q;
  assign bus.div_sign          = div_sign_q;
  assign bus.div_dividend_sign = div_dividend_sign_q;
  assign bus.div_dividend      = div_dividend_q;
  assign bus.div_divisor       = div_divisor_q;
  assign bus.stall             = stall_c;
  assign bus.hi                = hi_q;
  assign bus.lo                = lo_q;
  assign bus.timeout           = timeout_q;
endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: stimulus pushes expected {hi,lo} updates,
// a monitor pops and compares them whenever HI/LO change.
module tb_muldiv_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;

  muldiv_sched_if bus();

  muldiv_sched #(.MAX_WAIT(40)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb_q[$];
  logic [63:0] hl_model = '0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic v, input logic [2:0] op,
                           input logic [31:0] ra, input logic [31:0] rb);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.a         = ra;
    bus.b         = rb;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Launch one mul/div op, hold it while stalled, pulse done after n wait cycles.
  task automatic run_md(input string name, input logic [2:0] op,
                        input logic [31:0] ra, input logic [31:0] rb, input int n,
                        input logic [63:0] res, input logic [31:0] exp_x,
                        input logic [31:0] exp_y, input logic exp_s, input logic exp_ds);
    int   stalls;
    int   begins;
    logic is_mul;
    is_mul = (op < 3'd2);
    stalls = 0;
    begins = 0;
    drive_req(1'b1, op, ra, rb);
    @(negedge clk);
    if (bus.stall) stalls++;
    next_cycle();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.stall) stalls++;
      if (is_mul ? bus.mul_begin : bus.div_begin) begins++;
      if (i == 0) begin
        if (is_mul)
          check({name, "_mul_operands"}, 96'({bus.mul_sign, bus.mul_a, bus.mul_b}),
                96'({exp_s, exp_x, exp_y}));
        else
          check({name, "_div_operands"},
                96'({bus.div_sign, bus.div_dividend_sign, bus.div_dividend, bus.div_divisor}),
                96'({exp_s, exp_ds, exp_x, exp_y}));
      end
      next_cycle();
    end
    if (is_mul) begin
      bus.mul_res  = res;
      bus.mul_done = 1'b1;
    end else begin
      bus.div_remainder = res[63:32];
      bus.div_quotient  = res[31:0];
      bus.div_done      = 1'b1;
    end
    sb_q.push_back(res);
    hl_model = res;
    @(negedge clk);
    check({name, "_stall_on_done"}, 96'(bus.stall), 96'(0));
    if (is_mul ? bus.mul_begin : bus.div_begin) begins++;
    next_cycle();
    bus.mul_done = 1'b0;
    bus.div_done = 1'b0;
    drive_req(1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    check({name, "_idle_after"},
          96'({bus.mul_begin, bus.div_begin, bus.mul_a, bus.div_dividend}), 96'(0));
    check({name, "_stall_cycles"}, 96'(stalls), 96'(n + 1));
    check({name, "_begin_cycles"}, 96'(begins), 96'(n + 1));
  endtask

  // Scoreboard monitor: any HI/LO change must match the oldest expected update.
  initial begin
    logic [63:0] prev;
    logic [63:0] cur;
    prev = '0;
    wait (!rst);
    forever begin
      @(negedge clk);
      cur = {bus.hi, bus.lo};
      if (cur !== prev) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL hilo_unexpected: got 0x%0h, expected 0x%0h", cur, prev);
        end else begin
          check("hilo_update", 96'(cur), 96'(sb_q.pop_front()));
        end
        prev = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int   waits;
    int   to_cycles;
    logic to_seen;

    drive_req(1'b0, 3'd0, 32'd0, 32'd0);
    bus.flush         = 1'b0;
    bus.mul_res       = '0;
    bus.mul_done      = 1'b0;
    bus.div_quotient  = '0;
    bus.div_remainder = '0;
    bus.div_done      = 1'b0;
    repeat (2) next_cycle();
    rst = 1'b0;

    @(negedge clk);
    check("reset_hilo", 96'({bus.hi, bus.lo}), 96'(0));
    check("reset_ctrl", 96'({bus.stall, bus.timeout, bus.mul_begin, bus.div_begin,
                            bus.mul_sign, bus.div_sign, bus.div_dividend_sign}), 96'(0));
    check("reset_operands", 96'({bus.mul_a, bus.mul_b, bus.div_dividend}), 96'(0));
    next_cycle();

    run_md("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 3, 64'hFFFF_FFFF_FFFF_FFFA,
           32'd2, 32'd3, 1'b1, 1'b0);
    run_md("multu", 3'd1, 32'h0001_0000, 32'h0001_0000, 2, 64'h0000_0001_0000_0000,
           32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
    run_md("divu", 3'd3, 32'd100, 32'd7, 5, {32'd2, 32'd14}, 32'd100, 32'd7, 1'b0, 1'b0);
    run_md("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 4, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
           32'd7, 32'd2, 1'b1, 1'b1);

    // Divide by zero: nothing starts, nothing stalls, HI/LO untouched.
    drive_req(1'b1, 3'd2, 32'd9, 32'd0);
    @(negedge clk);
    check("div0_stall", 96'(bus.stall), 96'(0));
    next_cycle();
    drive_req(1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("div0_no_begin", 96'(bus.div_begin), 96'(0));
    check("div0_hilo", 96'({bus.hi, bus.lo}), 96'(hl_model));
    next_cycle();

    // Back-to-back MTHI then MTLO.
    drive_req(1'b1, 3'd4, 32'h1234_5678, 32'd0);
    hl_model = {32'h1234_5678, hl_model[31:0]};
    sb_q.push_back(hl_model);
    @(negedge clk);
    check("mthi_stall", 96'(bus.stall), 96'(0));
    next_cycle();
    drive_req(1'b1, 3'd5, 32'hCAFE_BABE, 32'd0);
    hl_model = {hl_model[63:32], 32'hCAFE_BABE};
    sb_q.push_back(hl_model);
    @(negedge clk);
    check("mtlo_stall", 96'(bus.stall), 96'(0));
    next_cycle();
    drive_req(1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("mthi_mtlo_hilo", 96'({bus.hi, bus.lo}), 96'({32'h1234_5678, 32'hCAFE_BABE}));
    next_cycle();

    // Flush in IDLE suppresses acceptance.
    drive_req(1'b1, 3'd0, 32'd3, 32'd4);
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_idle_stall", 96'(bus.stall), 96'(0));
    next_cycle();
    bus.flush = 1'b0;
    drive_req(1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("flush_idle_no_begin", 96'(bus.mul_begin), 96'(0));
    next_cycle();

    // MULTU with flush coincident with mul_done: result discarded.
    drive_req(1'b1, 3'd1, 32'd5, 32'd6);
    repeat (3) next_cycle();
    bus.mul_res  = 64'h0000_0000_0000_001E;
    bus.mul_done = 1'b1;
    bus.flush    = 1'b1;
    @(negedge clk);
    check("flush_done_stall", 96'(bus.stall), 96'(0));
    next_cycle();
    bus.mul_done = 1'b0;
    bus.flush    = 1'b0;
    drive_req(1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("flush_done_idle", 96'({bus.mul_begin, bus.mul_a, bus.mul_b}), 96'(0));
    check("flush_done_hilo", 96'({bus.hi, bus.lo}), 96'(hl_model));
    next_cycle();

    // DIVU that never completes; a stray mul_done must not end it early.
    drive_req(1'b1, 3'd3, 32'd5, 32'd1);
    next_cycle();
    drive_req(1'b0, 3'd0, 32'd0, 32'd0);
    waits     = 0;
    to_cycles = 0;
    to_seen   = 1'b0;
    for (int cyc = 0; cyc < 100 && !to_seen; cyc++) begin
      bus.mul_res  = 64'hDEAD_BEEF_0BAD_F00D;
      bus.mul_done = (cyc == 3);
      @(negedge clk);
      if (bus.div_begin) waits++;
      if (bus.timeout) begin
        to_seen = 1'b1;
        to_cycles++;
      end
      next_cycle();
    end
    bus.mul_done = 1'b0;
    check("timeout_seen", 96'(to_seen), 96'(1));
    check("timeout_wait_cycles", 96'(waits), 96'(40));
    @(negedge clk);
    if (bus.timeout) to_cycles++;
    check("timeout_single_pulse", 96'(to_cycles), 96'(1));
    check("timeout_idle", 96'({bus.div_begin, bus.stall, bus.div_dividend}), 96'(0));
    check("timeout_hilo", 96'({bus.hi, bus.lo}), 96'(hl_model));
    next_cycle();

    // Reset mid-operation, with a request present, then a stale done.
    drive_req(1'b1, 3'd0, 32'd3, 32'd4);
    next_cycle();
    rst = 1'b1;
    hl_model = '0;
    sb_q.push_back(hl_model);
    @(negedge clk);
    check("rst_stall", 96'(bus.stall), 96'(0));
    next_cycle();
    rst = 1'b0;
    drive_req(1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("rst_mid_op_idle", 96'({bus.mul_begin, bus.mul_sign, bus.mul_a, bus.mul_b}), 96'(0));
    next_cycle();
    bus.mul_res  = 64'h1111_2222_3333_4444;
    bus.mul_done = 1'b1;
    next_cycle();
    bus.mul_done = 1'b0;
    @(negedge clk);
    check("stale_done_hilo", 96'({bus.hi, bus.lo}), 96'(0));
    next_cycle();

    @(negedge clk);
    check("scoreboard_drained", 96'(sb_q.size()), 96'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_sched.md
MULDIV_SCHED -- requirements
Module: muldiv_sched

Interface
REQ-001 The module SHALL have one clock, clk; reset is rst, synchronous and active-high.
REQ-002 The module SHALL have the parameter MAX_WAIT, default 40, meaning the watchdog limit in cycles for one mul/div operation.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  EX stage presents a HI/LO-class operation this cycle.
REQ-006 req_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 ignored, treated as no request.
REQ-007 a, b  input  32 each  rs and rt operand values.
REQ-008 flush  input  1  kill the in-flight operation; raised on exception or ERET in a later stage.
REQ-009 mul_begin, mul_sign  output  1 each  level-held start and sign for the multiplier controller.
REQ-010 mul_a, mul_b  output  32 each  operand magnitudes for the multiplier.
REQ-011 mul_res  input  64  final signed product, valid while mul_done is high.
REQ-012 mul_done  input  1  single-cycle multiplier completion pulse.
REQ-013 div_begin, div_sign, div_dividend_sign  output  1 each  level-held start and signs for the divider controller.
REQ-014 div_dividend, div_divisor  output  32 each  operand magnitudes for the divider.
REQ-015 div_quotient, div_remainder  input  32 each  final signed results, valid while div_done is high.
REQ-016 div_done  input  1  single-cycle divider completion pulse.
REQ-017 stall  output  1  freeze the pipeline at EX and earlier stages.
REQ-018 hi, lo  output  32 each  architectural HI and LO registers.
REQ-019 timeout  output  1  one-cycle pulse when the watchdog fires.

Function
REQ-020 The FSM SHALL have the states IDLE, MUL_WAIT and DIV_WAIT.
REQ-021 IDLE with a MULT/MULTU request SHALL latch the operands and go to MUL_WAIT on the next edge.
 - Latched values: mul_sign = a[31]^b[31] for MULT, 0 for MULTU.
 - mul_a and mul_b = two's-complement magnitudes for MULT, raw values for MULTU.
REQ-022 IDLE with a DIV/DIVU request and b != 0 SHALL latch the operands and go to DIV_WAIT.
 - Latched values: div_sign = a[31]^b[31], div_dividend_sign = a[31], magnitudes for DIV.
 - For DIVU: signs 0 and raw values.
REQ-023 A DIV/DIVU request with b == 0 SHALL NOT start the divider, SHALL leave HI/LO unchanged and SHALL NOT stall.
REQ-024 mul_begin SHALL be high exactly while the state is MUL_WAIT; div_begin exactly while DIV_WAIT.
 - The operand and sign outputs SHALL hold their latched values for the whole wait and be 0 in IDLE.
REQ-025 In MUL_WAIT, mul_done SHALL load hi <= mul_res[63:32] and lo <= mul_res[31:0], and return the FSM to IDLE on the same edge.
REQ-026 In DIV_WAIT, div_done SHALL load hi <= div_remainder and lo <= div_quotient, and return the FSM to IDLE.
REQ-027 stall SHALL be combinational and high on either of:
 - IDLE with req_valid and a valid mul/div start (REQ-021, REQ-022);
 - any WAIT state without flush and without the matching done.
 - Consequence: the launch cycle stalls, and the cycle in which done arrives does not stall.
REQ-028 Minimum mul/div latency SHALL be 1 launch cycle + N wait cycles, where N is the controller latency; results SHALL be visible on hi/lo the cycle after done.
REQ-029 IDLE with MTHI SHALL load hi <= a, and MTLO SHALL load lo <= a, on the next edge with no stall.
REQ-030 Any request presented while in a WAIT state SHALL be ignored and stalled until the FSM returns to IDLE; the EX stage re-presents it.
REQ-031 flush SHALL force IDLE on the next edge, drop begin, and leave HI/LO unchanged.
 - If flush and done occur in the same cycle, flush SHALL win and the result is discarded.
 - flush in IDLE SHALL suppress acceptance of the current request.
REQ-032 A done pulse arriving in IDLE, or a pulse for the wrong unit, SHALL be ignored.
REQ-033 A wait counter SHALL clear on entry to a WAIT state and increment each WAIT cycle.
 - On reaching MAX_WAIT: pulse timeout, return to IDLE, leave HI/LO unchanged.
REQ-034 Each hi/lo output SHALL be driven directly from its register (no combinational bypass).

Reset
REQ-035 rst SHALL put the FSM in IDLE and set hi, lo, the wait counter, all begin/sign/operand outputs, stall and timeout to 0.
REQ-036 rst asserted mid-operation SHALL abandon the operation on the next edge; a later stale done SHALL be ignored per REQ-032.
REQ-037 rst SHALL take priority over flush and over every request.

Verification
REQ-038 MULT with a=0xFFFFFFFE, b=3 and a model mul_res=0xFFFFFFFF_FFFFFFFA after 3 cycles:
 - mul_a=2, mul_b=3, mul_sign=1;
 - stall high for 4 cycles;
 - then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-039 DIVU with a=100, b=7 and a model quotient 14, remainder 2: div_begin held until done, then hi=2, lo=14.
REQ-040 DIV with b=0: no begin, no stall, hi/lo keep their prior values.
REQ-041 MTHI 0x12345678, then MTLO 0xCAFEBABE on back-to-back cycles: hi=0x12345678, lo=0xCAFEBABE, stall never high.
REQ-042 MULTU launched, then flush coincident with mul_done: hi/lo unchanged, IDLE next cycle, stall low that cycle.
REQ-043 DIVU with done never asserted and MAX_WAIT=40: timeout pulses after 40 wait cycles, FSM returns to IDLE, hi/lo unchanged.
